top_k_selector: RTL
===================

Name: top_k_selector

Overview:
- Sits directly downstream of the packet parser FIFO.
- Consumes the 33-bit {tlast, data[31:0]} stream and the 16-bit lane-enable word that the parser produces.
- Keeps the K largest unsigned 32-bit values of a batch in a sorted register array, one insertion per cycle.
- When the batch's tlast beat arrives, emits the kept values largest-first as a 33-bit {tlast, data} stream toward the result packer.

Parameters:
- K, 8, number of values retained and emitted per batch (2..16).
- LANE, 0, bit index of the enable word that gates this instance (0..15).

Ports:
- clk  in  1  kernel clock.
- rst  in  1  asynchronous, active-low reset.
- s_tdata  in  33  bit32 = tlast, [31:0] = unsigned value.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat accepted when s_tvalid & s_tready.
- enable  in  16  lane-enable word from the parser; held stable by the parser between updates.
- m_tdata  out  33  bit32 = tlast of result batch, [31:0] = value.
- m_tvalid  out  1  result beat valid.
- m_tready  in  1  downstream ready.

Behaviour:
- Reset (rst low, asynchronous):
  - state = COLLECT, count = 0, all K slots = 0.
  - s_tready = 0, m_tvalid = 0, m_tdata = 0.
  - Takes effect immediately, including mid-batch or mid-emit; the partial batch is discarded.
  - First cycle after release: s_tready = 1.
- States: COLLECT, EMIT.
- COLLECT:
  - s_tready = 1, m_tvalid = 0.
  - Accepted beat with enable[LANE] = 1:
    - Compare the value against all slots in parallel (unsigned). Slots are kept descending, slot0 = largest.
    - Insert at the first position whose slot holds a strictly smaller value, or at position count if none. Lower slots shift down by one and the last slot falls off when full.
    - Ties: the new value goes after existing equal values.
    - count saturates at K.
    - When count = K and value <= slot[K-1], the array is unchanged.
  - Accepted beat with enable[LANE] = 0: data is dropped and the array is unchanged.
  - Accepted beat with tlast = 1:
    - The insertion (if enabled) completes in the same cycle.
    - If the post-insert count > 0, go to EMIT next cycle; otherwise stay in COLLECT with nothing emitted.
  - Latency: last beat accepted in cycle t gives m_tvalid = 1 with slot0 in cycle t+1.
- EMIT:
  - s_tready = 0. m_tvalid = 1, m_tdata = {last, slot[idx]}, idx starting at 0.
  - last = 1 when idx = count-1.
  - On m_tvalid & m_tready: idx increments. After the last handshake, clear count, slots and idx, and return to COLLECT.
  - When m_tready is held low, m_tdata is held stable.
  - One beat per cycle when m_tready stays high; a batch of n kept values (n = min(count, K)) emits in n cycles.
- No input is accepted during EMIT. The first beat of the next batch is accepted one cycle after the final emit handshake at the earliest.
- enable is sampled per accepted beat, with no internal latching.

Optional Feature:
- Macro: TOP_K_BATCH_COUNT_EN.
- When defined:
  - Adds outputs batch_count (32) and batch_count_valid (1).
  - batch_count counts every accepted enabled beat of the current batch, saturating at 2^32-1. It is not limited by K.
  - On entry to EMIT, batch_count holds the batch total and batch_count_valid pulses high for exactly 1 cycle.
  - Both reset to 0 and are cleared on return to COLLECT.
- When undefined: the ports and the counter do not exist, and behaviour is otherwise identical.

Test Plan:
- K=8, enable[0]=1. Values 5,3,9,1,7,2,8,6,4,10 (tlast on 10) -> emits 10,9,8,7,6,5,4,3; tlast only on 3; first m_tvalid one cycle after 10 accepted.
- Three beats 4,4,2 (tlast on 2) -> emits exactly 3 beats: 4,4,2, tlast on 2. Next batch 1 (tlast) -> single beat 1 with tlast.
- enable[0]=0 for beats 100,200, then enable[0]=1 for 3 (tlast) -> emits only 3. Batch entirely disabled -> no output, stays in COLLECT.
- Backpressure: m_tready toggles 1,0,0,1 during emit -> m_tdata stable while stalled, no beat lost or duplicated; s_tready=0 throughout EMIT.
- Reset asserted mid-collection after 5 beats, and again mid-emit at idx 2 -> outputs 0 at once; after release, the next batch 0xFFFFFFFF,0 (tlast) emits 0xFFFFFFFF,0 with no leftover values.
- With TOP_K_BATCH_COUNT_EN, 20 enabled beats -> batch_count = 20 with a one-cycle batch_count_valid pulse, and exactly K = 8 beats emitted.

Source files
------------

// File: rtl/top_k_selector.sv
// top_k_selector: keeps the K largest unsigned values of a batch sorted, emits them largest-first on tlast.
// Optional TOP_K_BATCH_COUNT_EN adds batch_count/batch_count_valid outputs.
module top_k_selector #(
    parameter int K    = 8,
    parameter int LANE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [32:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [15:0] enable,
    output logic [32:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready
`ifdef TOP_K_BATCH_COUNT_EN
    ,
    output logic [31:0] batch_count,
    output logic        batch_count_valid
`endif
);
    localparam int CW = $clog2(K + 1);
    localparam int KW = $clog2(K);

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d, pos;
    logic [KW-1:0] idx_q, idx_d, nidx;
    logic [31:0]   slot_q [K];
    logic [31:0]   slot_d [K];
    logic          s_tready_q, s_tready_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic [32:0]   m_tdata_q, m_tdata_d;
    logic          acc, ins, emit_last;
    logic [31:0]   v;

    assign v = s_tdata[31:0];

    // First occupied slot strictly smaller than v; equal values stay ahead of the newcomer.
    always_comb begin
        pos = count_q;
        for (int i = K - 1; i >= 0; i--)
            if (CW'(i) < count_q && slot_q[i] < v) pos = CW'(i);
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        slot_d     = slot_q;
        s_tready_d = s_tready_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        acc        = s_tvalid & s_tready_q;
        ins        = acc && enable[LANE] && pos < CW'(K);
        nidx       = idx_q + KW'(1);
        emit_last  = CW'(idx_q) == count_q - CW'(1);
        if (state_q == COLLECT) begin
            s_tready_d = 1'b1;
            if (ins) begin
                for (int i = 1; i < K; i++)
                    if (CW'(i) > pos) slot_d[i] = slot_q[i-1];
                for (int i = 0; i < K; i++)
                    if (CW'(i) == pos) slot_d[i] = v;
                count_d = (count_q == CW'(K)) ? count_q : count_q + CW'(1);
            end
            if (acc && s_tdata[32] && count_d != '0) begin
                state_d    = EMIT;
                idx_d      = '0;
                s_tready_d = 1'b0;
                m_tvalid_d = 1'b1;
                m_tdata_d  = {count_d == CW'(1), slot_d[0]};
            end
        end else if (m_tready) begin
            if (emit_last) begin
                state_d    = COLLECT;
                count_d    = '0;
                idx_d      = '0;
                slot_d     = '{default: '0};
                s_tready_d = 1'b1;
                m_tvalid_d = 1'b0;
                m_tdata_d  = '0;
            end else begin
                idx_d     = nidx;
                m_tdata_d = {CW'(nidx) == count_q - CW'(1), slot_q[nidx]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= COLLECT;
            count_q    <= '0;
            idx_q      <= '0;
            slot_q     <= '{default: '0};
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            slot_q     <= slot_d;
            s_tready_q <= s_tready_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
        end
    end

    assign s_tready = s_tready_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = m_tdata_q;

`ifdef TOP_K_BATCH_COUNT_EN
    logic [31:0] bc_q, bc_d;
    logic        bcv_q, bcv_d;

    // Counts every enabled beat, independent of how many fit in the K slots.
    always_comb begin
        bc_d  = bc_q;
        bcv_d = 1'b0;
        if (state_q == COLLECT) begin
            if (acc && enable[LANE]) bc_d = (&bc_q) ? bc_q : bc_q + 32'd1;
            if (state_d == EMIT) bcv_d = 1'b1;
            if (acc && s_tdata[32] && state_d == COLLECT) bc_d = '0;
        end else if (state_d == COLLECT) begin
            bc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bc_q  <= '0;
            bcv_q <= 1'b0;
        end else begin
            bc_q  <= bc_d;
            bcv_q <= bcv_d;
        end
    end

    assign batch_count       = bc_q;
    assign batch_count_valid = bcv_q;
`endif
endmodule
